// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width and the transaction-arbiter state encoding.
package spi_pkg;
    localparam int SPI_DW = 12;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_ACTIVE,
        ARB_GAP
    } arb_state_e;
endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    int j;

    // Scan from farthest to nearest so the nearest valid request overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                any_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI master: issues newd/din, follows cs through the frame,
// enforces a cs-high gap between frames and reports done/timeout per requester.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = SPI_DW,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         req_done,
    output logic [NREQ-1:0]         req_err,
    output logic                    m_newd,
    output logic [DW-1:0]           m_din,
    input  logic                    m_cs,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    arb_state_e      state_q;
    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [TW-1:0]   tcnt_q;
    logic [GW-1:0]   gcnt_q;
    logic [NREQ-1:0] req_ready_q, req_done_q, req_err_q;
    logic            m_newd_q, busy_q;
    logic [DW-1:0]   m_din_q;
    logic [IW-1:0]   grant_id_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            m_newd_q    <= 1'b0;
            m_din_q     <= '0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (arb_any) begin
                        req_ready_q <= arb_gnt;
                        gnt_q       <= arb_gnt;
                        m_din_q     <= req_data[arb_idx*DW +: DW];
                        grant_id_q  <= arb_idx;
                        ptr_q       <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                        m_newd_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        tcnt_q      <= '0;
                        state_q     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // A cs already low here (stale frame) still counts as started.
                    if (!m_cs) begin
                        m_newd_q <= 1'b0;
                        tcnt_q   <= '0;
                        state_q  <= ARB_ACTIVE;
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        m_newd_q  <= 1'b0;
                        req_err_q <= gnt_q;
                        gcnt_q    <= '0;
                        state_q   <= ARB_GAP;
                    end else if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                ARB_ACTIVE: begin
                    if (m_cs) begin
                        req_done_q <= gnt_q;
                        gcnt_q     <= '0;
                        state_q    <= ARB_GAP;
                    end
                end
                ARB_GAP: begin
                    if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        gcnt_q  <= '0;
                        state_q <= ARB_IDLE;
                    end else if (gcnt_q != '1) begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                default: begin
                    m_newd_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign m_newd    = m_newd_q;
    assign m_din     = m_din_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
endmodule
